register_bank_arbiter: RTL and testbench

//  Shares one WIDTH-bit bank of async-preset/reset D flip-flops among NUM_REQ requesters.

---
 rtl/register_bank_pkg.sv | 20 ++
 rtl/register_bank_arbiter_rr.sv | 43 ++++
 rtl/register_bank_arbiter.sv | 164 ++++++++++++++++
 tb/tb_register_bank_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
// Shared encodings for the register bank arbiter: command codes and FSM state codes.
package register_bank_pkg;

    // Requester command codes (cmd slice per requester)
    localparam logic [1:0] CMD_LOAD   = 2'b00;
    localparam logic [1:0] CMD_CLEAR  = 2'b01;
    localparam logic [1:0] CMD_PRESET = 2'b10;
    localparam logic [1:0] CMD_READ   = 2'b11;

    // Sequencer states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXEC    = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    // Commands that drive a timed active-low pulse into the bank
    function automatic logic is_pulse_cmd(input logic [1:0] c);
        return (c == CMD_CLEAR) || (c == CMD_PRESET);
    endfunction

endpackage

// File: rtl/register_bank_arbiter_rr.sv
// Round-robin selector: first requester with req=1 at or after ptr, wrapping at NUM_REQ.
// Ports:
//   req           in   NUM_REQ  request levels
//   ptr           in   PTR_W    index with highest priority this round
//   winner_c      out  NUM_REQ  one-hot winner (combinational)
//   winner_idx_c  out  PTR_W    index of the winner (combinational)
//   valid_c       out  1        at least one request present (combinational)
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner_c,
    output logic [PTR_W-1:0]   winner_idx_c,
    output logic               valid_c
);

    // Scan from the lowest priority slot down so the highest-priority hit is written last
    always_comb begin
        int               j;
        logic [PTR_W-1:0] jj;
        winner_c     = '0;
        winner_idx_c = '0;
        valid_c      = 1'b0;
        j            = 0;
        jj           = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= int'(NUM_REQ)) begin
                j = j - int'(NUM_REQ);
            end
            jj = PTR_W'(j);
            if (req[jj]) begin
                winner_c     = '0;
                winner_c[jj] = 1'b1;
                winner_idx_c = jj;
                valid_c      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/register_bank_arbiter.sv
// Shares one flip-flop bank among NUM_REQ requesters. Round-robin arbitration picks one
// LOAD/CLEAR/PRESET/READ command at a time and sequences the bank strobes with fixed timing.
// Ports:
//   clock_pos        in   1              clock, rising edge
//   reset_neg        in   1              synchronous active-low reset
//   req              in   NUM_REQ        per-requester request level
//   cmd              in   2*NUM_REQ      per-requester command, slice i = cmd[2i+1:2i]
//   data_in          in   NUM_REQ*WIDTH  per-requester LOAD data
//   grant            out  NUM_REQ        one-hot grant, held for the whole operation
//   done             out  NUM_REQ        one-cycle completion pulse
//   rd_data          out  WIDTH          bank value captured by the last READ
//   busy             out  1              sequencer not idle
//   bank_data        out  WIDTH          data presented to the bank
//   bank_load        out  1              bank load strobe
//   bank_preset_neg  out  1              active-low bank preset
//   bank_reset_neg   out  1              active-low bank reset
//   bank_q           in   WIDTH          current bank outputs
module register_bank_arbiter
    import register_bank_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PULSE_LEN = 2
) (
    input  logic                     clock_pos,
    input  logic                     reset_neg,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [2*NUM_REQ-1:0]     cmd,
    input  logic [NUM_REQ*WIDTH-1:0] data_in,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     busy,
    output logic [WIDTH-1:0]         bank_data,
    output logic                     bank_load,
    output logic                     bank_preset_neg,
    output logic                     bank_reset_neg,
    input  logic [WIDTH-1:0]         bank_q
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(PULSE_LEN + 1);

    logic [1:0]         state,     state_nxt;
    logic [PTR_W-1:0]   ptr,       ptr_nxt;
    logic [PTR_W-1:0]   win_idx,   win_idx_nxt;
    logic [1:0]         cmd_q,     cmd_q_nxt;
    logic [CNT_W-1:0]   cnt,       cnt_nxt;
    logic [NUM_REQ-1:0] grant_nxt, done_nxt;
    logic [WIDTH-1:0]   rd_data_nxt, bank_data_nxt;
    logic               busy_nxt, bank_load_nxt, bank_preset_neg_nxt, bank_reset_neg_nxt;

    logic [NUM_REQ-1:0] arb_winner_c;
    logic [PTR_W-1:0]   arb_idx_c;
    logic               arb_valid_c;
    logic [1:0]         sel_cmd_c;
    logic [WIDTH-1:0]   sel_data_c;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req          (req),
        .ptr          (ptr),
        .winner_c     (arb_winner_c),
        .winner_idx_c (arb_idx_c),
        .valid_c      (arb_valid_c)
    );

    // Command and data of the current arbitration winner
    assign sel_cmd_c  = cmd[2*int'(arb_idx_c) +: 2];
    assign sel_data_c = data_in[WIDTH*int'(arb_idx_c) +: WIDTH];

    // Next-state and registered-output logic
    always_comb begin
        state_nxt           = state;
        ptr_nxt             = ptr;
        win_idx_nxt         = win_idx;
        cmd_q_nxt           = cmd_q;
        cnt_nxt             = cnt;
        grant_nxt           = grant;
        done_nxt            = '0;
        rd_data_nxt         = rd_data;
        bank_data_nxt       = bank_data;
        bank_load_nxt       = 1'b0;
        bank_preset_neg_nxt = 1'b1;
        bank_reset_neg_nxt  = 1'b1;

        case (state)
            ST_IDLE: begin
                if (arb_valid_c) begin
                    state_nxt           = ST_EXEC;
                    grant_nxt           = arb_winner_c;
                    win_idx_nxt         = arb_idx_c;
                    cmd_q_nxt           = sel_cmd_c;
                    bank_data_nxt       = sel_data_c;
                    cnt_nxt             = CNT_W'(PULSE_LEN - 1);
                    // Bank lines for the first EXEC cycle are registered on the grant edge
                    bank_load_nxt       = (sel_cmd_c == CMD_LOAD);
                    bank_reset_neg_nxt  = (sel_cmd_c != CMD_CLEAR);
                    bank_preset_neg_nxt = (sel_cmd_c != CMD_PRESET);
                end
            end
            ST_EXEC: begin
                if (is_pulse_cmd(cmd_q) && (cnt != '0)) begin
                    cnt_nxt             = cnt - CNT_W'(1);
                    bank_reset_neg_nxt  = (cmd_q != CMD_CLEAR);
                    bank_preset_neg_nxt = (cmd_q != CMD_PRESET);
                end else begin
                    state_nxt = ST_RECOVER;
                    done_nxt  = grant;
                    if (cmd_q == CMD_READ) begin
                        rd_data_nxt = bank_q;
                    end
                end
            end
            ST_RECOVER: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
                ptr_nxt   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clock_pos) begin
        if (!reset_neg) begin
            state           <= ST_IDLE;
            ptr             <= '0;
            win_idx         <= '0;
            cmd_q           <= CMD_LOAD;
            cnt             <= '0;
            grant           <= '0;
            done            <= '0;
            rd_data         <= '0;
            busy            <= 1'b0;
            bank_data       <= '0;
            bank_load       <= 1'b0;
            bank_preset_neg <= 1'b1;
            bank_reset_neg  <= 1'b1;
        end else begin
            state           <= state_nxt;
            ptr             <= ptr_nxt;
            win_idx         <= win_idx_nxt;
            cmd_q           <= cmd_q_nxt;
            cnt             <= cnt_nxt;
            grant           <= grant_nxt;
            done            <= done_nxt;
            rd_data         <= rd_data_nxt;
            busy            <= busy_nxt;
            bank_data       <= bank_data_nxt;
            bank_load       <= bank_load_nxt;
            bank_preset_neg <= bank_preset_neg_nxt;
            bank_reset_neg  <= bank_reset_neg_nxt;
        end
    end

endmodule

// File: tb/tb_register_bank_arbiter.sv
// Bench for register_bank_arbiter: transaction-level model of arbitration order, bank
// contents and command timing, with a behavioural flip-flop bank attached to the DUT.
module tb_register_bank_arbiter;
    import register_bank_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 8;
    localparam int PULSE_LEN = 2;

    logic                     clock_pos = 1'b0;
    logic                     reset_neg;
    logic [NUM_REQ-1:0]       req;
    logic [2*NUM_REQ-1:0]     cmd;
    logic [NUM_REQ*WIDTH-1:0] data_in;
    logic [NUM_REQ-1:0]       grant, done;
    logic [WIDTH-1:0]         rd_data, bank_data;
    logic                     busy, bank_load, bank_preset_neg, bank_reset_neg;
    logic [WIDTH-1:0]         bank_q = '0;

    // Reference state
    logic [NUM_REQ-1:0] m_req;
    logic [1:0]         m_cmd  [NUM_REQ];
    logic [WIDTH-1:0]   m_data [NUM_REQ];
    int                 m_ptr;
    logic [WIDTH-1:0]   m_bank, m_rd;
    int                 n_tests = 0;
    int                 n_fail  = 0;

    // Observed control vector: grant, done, busy, load, preset_n, reset_n
    logic [2*NUM_REQ+3:0] obs;
    assign obs = {grant, done, busy, bank_load, bank_preset_neg, bank_reset_neg};

    register_bank_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .PULSE_LEN (PULSE_LEN)
    ) dut (
        .clock_pos       (clock_pos),
        .reset_neg       (reset_neg),
        .req             (req),
        .cmd             (cmd),
        .data_in         (data_in),
        .grant           (grant),
        .done            (done),
        .rd_data         (rd_data),
        .busy            (busy),
        .bank_data       (bank_data),
        .bank_load       (bank_load),
        .bank_preset_neg (bank_preset_neg),
        .bank_reset_neg  (bank_reset_neg),
        .bank_q          (bank_q)
    );

    always #5 clock_pos = ~clock_pos;

    // Flip-flop bank: reset beats preset beats load
    always @(posedge clock_pos) begin
        if (!bank_reset_neg)       bank_q <= '0;
        else if (!bank_preset_neg) bank_q <= '1;
        else if (bank_load)        bank_q <= bank_data;
    end

    task automatic step();
        @(posedge clock_pos);
        #1;
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i]                   = m_req[i];
            cmd[2*i +: 2]            = m_cmd[i];
            data_in[WIDTH*i +: WIDTH] = m_data[i];
        end
    endtask

    function automatic int pick();
        for (int i = 0; i < NUM_REQ; i++) begin
            int j;
            j = (m_ptr + i) % NUM_REQ;
            if (m_req[j]) return j;
        end
        return -1;
    endfunction

    // One complete operation starting from an IDLE cycle with requests already driven
    task automatic run_op(input bit drop);
        int                   w, n, lat, exp_lat;
        logic [1:0]           c;
        logic [WIDTH-1:0]     d;
        logic [NUM_REQ-1:0]   oh;
        logic [2*NUM_REQ+3:0] exp;
        w = pick();
        n_tests++;
        if (w < 0) begin
            n_fail++;
            $display("FAIL run_op: no pending request in model, req=%b", m_req);
            return;
        end
        c       = m_cmd[w];
        d       = m_data[w];
        oh      = NUM_REQ'(1) << w;
        n       = is_pulse_cmd(c) ? PULSE_LEN : 1;
        exp_lat = is_pulse_cmd(c) ? 2 + PULSE_LEN : 3;
        lat     = 1;
        step(); lat++;
        for (int j = 0; j < n; j++) begin
            exp = {oh, NUM_REQ'(0), 1'b1, c == CMD_LOAD, c != CMD_PRESET, c != CMD_CLEAR};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL exec req%0d cmd%0d cyc%0d: got %b want %b", w, c, j, obs, exp);
            end
            if (c == CMD_LOAD) begin
                n_tests++;
                if (bank_data !== d) begin
                    n_fail++;
                    $display("FAIL bank_data req%0d: got %h want %h", w, bank_data, d);
                end
            end
            // Inputs changed after the winner is latched must be ignored
            if (drop && j == 0) begin
                m_cmd[w]  = 2'($urandom);
                m_data[w] = WIDTH'($urandom);
                drive();
            end
            step(); lat++;
        end
        case (c)
            CMD_LOAD:   m_bank = d;
            CMD_CLEAR:  m_bank = '0;
            CMD_PRESET: m_bank = '1;
            default:    m_rd   = m_bank;
        endcase
        exp = {oh, oh, 1'b1, 1'b0, 1'b1, 1'b1};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL recover req%0d cmd%0d: got %b want %b", w, c, obs, exp);
        end
        n_tests++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL latency req%0d cmd%0d: got %0d want %0d", w, c, lat, exp_lat);
        end
        n_tests++;
        if (rd_data !== m_rd) begin
            n_fail++;
            $display("FAIL rd_data req%0d cmd%0d: got %h want %h", w, c, rd_data, m_rd);
        end
        n_tests++;
        if (bank_q !== m_bank) begin
            n_fail++;
            $display("FAIL bank_q req%0d cmd%0d: got %h want %h", w, c, bank_q, m_bank);
        end
        m_ptr = (w + 1) % NUM_REQ;
        if (drop) begin
            m_req[w] = 1'b0;
            drive();
        end
        step();
        exp = {NUM_REQ'(0), NUM_REQ'(0), 1'b0, 1'b0, 1'b1, 1'b1};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL idle after req%0d: got %b want %b", w, obs, exp);
        end
    endtask

    task automatic test_reset(input int cycles);
        logic [2*NUM_REQ+3:0] exp;
        exp       = {NUM_REQ'(0), NUM_REQ'(0), 1'b0, 1'b0, 1'b1, 1'b1};
        reset_neg = 1'b0;
        m_req     = '1;
        drive();
        repeat (cycles) step();
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset ctrl: got %b want %b", obs, exp);
        end
        n_tests++;
        if ({rd_data, bank_data} !== '0) begin
            n_fail++;
            $display("FAIL reset data: rd_data=%h bank_data=%h want 0", rd_data, bank_data);
        end
        m_req     = '0;
        drive();
        reset_neg = 1'b1;
        m_ptr     = 0;
        m_rd      = '0;
        step();
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL idle after reset: got %b want %b", obs, exp);
        end
    endtask

    task automatic test_load();
        m_req[2] = 1'b1; m_cmd[2] = CMD_LOAD; m_data[2] = 8'hA5;
        drive();
        run_op(1'b1);
    endtask

    task automatic test_rotation();
        test_reset(1);
        for (int i = 0; i < NUM_REQ; i++) begin
            m_cmd[i]  = CMD_LOAD;
            m_data[i] = WIDTH'($urandom);
        end
        m_req = '1;
        drive();
        repeat (NUM_REQ + 1) run_op(1'b0);
        m_req = '0;
        drive();
    endtask

    task automatic test_pulses();
        m_req[1] = 1'b1; m_cmd[1] = CMD_CLEAR;
        drive();
        run_op(1'b1);
        m_req[1] = 1'b1; m_cmd[1] = CMD_PRESET;
        drive();
        run_op(1'b1);
    endtask

    task automatic test_read();
        m_req[0] = 1'b1; m_cmd[0] = CMD_LOAD; m_data[0] = 8'h3C;
        drive();
        run_op(1'b1);
        m_req[3] = 1'b1; m_cmd[3] = CMD_READ;
        drive();
        run_op(1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 15; r++) begin
            m_req = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++) begin
                m_cmd[i]  = 2'($urandom);
                m_data[i] = WIDTH'($urandom);
            end
            drive();
            for (int k = 0; k < NUM_REQ; k++) begin
                if (m_req != '0) run_op(1'b1);
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [2*NUM_REQ+3:0] exp;
        // Move the pointer away from 0 first
        m_req[1] = 1'b1; m_cmd[1] = CMD_LOAD; m_data[1] = 8'h5A;
        drive();
        run_op(1'b1);
        m_req[2] = 1'b1; m_cmd[2] = CMD_PRESET;
        drive();
        step();
        exp = {NUM_REQ'(4), NUM_REQ'(0), 1'b1, 1'b0, 1'b0, 1'b1};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL preset start: got %b want %b", obs, exp);
        end
        reset_neg = 1'b0;
        m_req     = '0;
        drive();
        step();
        m_bank = '1;
        m_rd   = '0;
        exp = {NUM_REQ'(0), NUM_REQ'(0), 1'b0, 1'b0, 1'b1, 1'b1};
        n_tests++;
        if (obs !== exp || rd_data !== m_rd) begin
            n_fail++;
            $display("FAIL mid-pulse reset: got %b rd=%h want %b rd=%h", obs, rd_data, exp, m_rd);
        end
        reset_neg = 1'b1;
        m_ptr     = 0;
        step();
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL after mid-pulse reset: got %b want %b", obs, exp);
        end
        // Pointer back at 0: requester 1 must beat requester 3
        m_req = 4'b1010;
        m_cmd[1] = CMD_READ; m_cmd[3] = CMD_LOAD; m_data[3] = 8'hC3;
        drive();
        run_op(1'b1);
        run_op(1'b1);
    endtask

    initial begin
        reset_neg = 1'b0;
        m_req     = '0;
        m_ptr     = 0;
        m_bank    = '0;
        m_rd      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            m_cmd[i]  = CMD_LOAD;
            m_data[i] = '0;
        end
        drive();
        test_reset(3);
        test_load();
        test_rotation();
        test_pulses();
        test_read();
        test_random();
        test_reset_mid_pulse();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
